// File: rtl/ama_riscv_pipe_ctrl_pkg.sv
// Shared core defines: opcodes, instruction field positions and pipe sequencer encodings.
// Pure declarations with no timing or flow control of their own.
package ama_riscv_pipe_ctrl_pkg;

   localparam logic [6:0] OPC7_R_TYPE = 7'b011_0011;
   localparam logic [6:0] OPC7_I_TYPE = 7'b001_0011;
   localparam logic [6:0] OPC7_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC7_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC7_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC7_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC7_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC7_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC7_AUIPC  = 7'b001_0111;

   localparam int OPC7_MSB = 6;
   localparam int OPC7_LSB = 0;
   localparam int RD_MSB   = 11;
   localparam int RD_LSB   = 7;
   localparam int RS1_MSB  = 19;
   localparam int RS1_LSB  = 15;
   localparam int RS2_MSB  = 24;
   localparam int RS2_LSB  = 20;

   typedef enum logic [1:0] {
      PIPE_ST_RST_SEQ  = 2'd0,
      PIPE_ST_RUN      = 2'd1,
      PIPE_ST_MEM_WAIT = 2'd2
   } pipe_st_t;

   typedef struct packed {
      logic pc_we;
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic clear_id;
      logic clear_ex;
      logic clear_mem;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RST    = '{clear_id: 1'b1, clear_ex: 1'b1, clear_mem: 1'b1, default: 1'b0};
   localparam pipe_ctrl_t CTRL_FREEZE = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mem: 1'b1, default: 1'b0};
   localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_we: 1'b1, clear_id: 1'b1, clear_ex: 1'b1, default: 1'b0};
   localparam pipe_ctrl_t CTRL_LU     = '{stall_if: 1'b1, stall_id: 1'b1, clear_ex: 1'b1, default: 1'b0};
   localparam pipe_ctrl_t CTRL_GO     = '{pc_we: 1'b1, default: 1'b0};

endpackage

// File: rtl/ama_riscv_pipe_ctrl_if.sv
// Pipe sequencer bundle: instructions and status in, pipeline-register controls and counters out.
// master is the sequencer side, slave is the datapath side.
interface ama_riscv_pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      inst_id;
   logic [31:0]      inst_ex;
   logic             flow_change;
   logic             dmem_busy;
   logic             pc_we;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             stall_mem;
   logic             clear_id;
   logic             clear_ex;
   logic             clear_mem;
   logic             running;
   logic             err_dmem_timeout;
   logic [CNT_W-1:0] cnt_load_use;
   logic [CNT_W-1:0] cnt_flush;
   logic [CNT_W-1:0] cnt_mem_wait;

   modport master (
      input  inst_id, inst_ex, flow_change, dmem_busy,
      output pc_we, stall_if, stall_id, stall_ex, stall_mem,
      output clear_id, clear_ex, clear_mem, running, err_dmem_timeout,
      output cnt_load_use, cnt_flush, cnt_mem_wait
   );

   modport slave (
      output inst_id, inst_ex, flow_change, dmem_busy,
      input  pc_we, stall_if, stall_id, stall_ex, stall_mem,
      input  clear_id, clear_ex, clear_mem, running, err_dmem_timeout,
      input  cnt_load_use, cnt_flush, cnt_mem_wait
   );
endinterface

// File: rtl/ama_riscv_hazard_det.sv
// Load-use detector: a LOAD in EX whose nonzero rd feeds a source register actually read in ID.
// Purely combinational, zero latency.
module ama_riscv_hazard_det
   import ama_riscv_pipe_ctrl_pkg::*;
(
   input  logic [31:0] i_inst_id,
   input  logic [31:0] i_inst_ex,
   output logic        o_load_use
);
   logic       w_rs1_used;
   logic       w_rs2_used;
   logic [4:0] w_rd_ex;
   logic [4:0] w_rs1_id;
   logic [4:0] w_rs2_id;
   logic       w_unused_bits;

   assign w_rd_ex  = i_inst_ex[RD_MSB:RD_LSB];
   assign w_rs1_id = i_inst_id[RS1_MSB:RS1_LSB];
   assign w_rs2_id = i_inst_id[RS2_MSB:RS2_LSB];
   assign w_unused_bits = ^{i_inst_ex[31:12], i_inst_id[31:25], i_inst_id[14:7]};

   // Immediate-only formats may carry rs-looking bits; only real source reads count.
   always_comb begin
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (i_inst_id[OPC7_MSB:OPC7_LSB])
         OPC7_R_TYPE, OPC7_STORE, OPC7_BRANCH: begin
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         OPC7_I_TYPE, OPC7_LOAD, OPC7_JALR: begin
            w_rs1_used = 1'b1;
         end
         default: begin
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
         end
      endcase
   end

   assign o_load_use = (i_inst_ex[OPC7_MSB:OPC7_LSB] == OPC7_LOAD) && (w_rd_ex != 5'd0) &&
                       ((w_rs1_used && (w_rs1_id == w_rd_ex)) || (w_rs2_used && (w_rs2_id == w_rd_ex)));

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline sequencer: reset clearing, load-use stall, flow-change flush and dmem-busy freeze.
// Controls are same-cycle from state and inputs; dmem_busy freezes every stage, bounded by a timeout.
module ama_riscv_pipe_ctrl
   import ama_riscv_pipe_ctrl_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int DMEM_WAIT_MAX = 15
)
(
   input  logic                  clk,
   input  logic                  rst,
   ama_riscv_pipe_ctrl_if.master bus
);
   localparam logic [5:0] WAIT_MAX = 6'(DMEM_WAIT_MAX);

   pipe_st_t         r_state;
   logic [1:0]       r_seq_cnt;
   logic [5:0]       r_wait_cnt;
   logic             r_busy_mask;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt_load_use;
   logic [CNT_W-1:0] r_cnt_flush;
   logic [CNT_W-1:0] r_cnt_mem_wait;

   logic       w_load_use;
   logic       w_timeout;
   logic       w_eval_run;
   logic       w_busy_run;
   logic       w_freeze;
   logic       w_flush;
   logic       w_lu_stall;
   pipe_ctrl_t w_ctrl;

   ama_riscv_hazard_det u_hazard_det (
      .i_inst_id  (bus.inst_id),
      .i_inst_ex  (bus.inst_ex),
      .o_load_use (w_load_use)
   );

   // A timeout cycle behaves like dmem_busy=0; the mask then ignores busy until it drops.
   assign w_timeout  = (r_state == PIPE_ST_MEM_WAIT) && bus.dmem_busy && (r_wait_cnt == WAIT_MAX);
   assign w_eval_run = (r_state == PIPE_ST_RUN) ||
                       ((r_state == PIPE_ST_MEM_WAIT) && (!bus.dmem_busy || w_timeout));
   assign w_busy_run = (r_state == PIPE_ST_RUN) && bus.dmem_busy && !r_busy_mask;
   assign w_freeze   = w_busy_run ||
                       ((r_state == PIPE_ST_MEM_WAIT) && bus.dmem_busy && !w_timeout);
   assign w_flush    = w_eval_run && !w_busy_run && bus.flow_change;
   assign w_lu_stall = w_eval_run && !w_busy_run && !bus.flow_change && w_load_use;

   always_comb begin
      w_ctrl = '0;
      if (rst) begin
         w_ctrl = CTRL_RST;
      end else if (r_state == PIPE_ST_RST_SEQ) begin
         w_ctrl.pc_we     = 1'b1;
         w_ctrl.clear_id  = (r_seq_cnt == 2'd0);
         w_ctrl.clear_ex  = (r_seq_cnt != 2'd2);
         w_ctrl.clear_mem = 1'b1;
      end else if (w_freeze) begin
         w_ctrl = CTRL_FREEZE;
      end else if (w_flush) begin
         w_ctrl = CTRL_FLUSH;
      end else if (w_lu_stall) begin
         w_ctrl = CTRL_LU;
      end else begin
         w_ctrl = CTRL_GO;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= PIPE_ST_RST_SEQ;
         r_seq_cnt      <= 2'd0;
         r_wait_cnt     <= 6'd0;
         r_busy_mask    <= 1'b0;
         r_err          <= 1'b0;
         r_cnt_load_use <= '0;
         r_cnt_flush    <= '0;
         r_cnt_mem_wait <= '0;
      end else begin
         if (!bus.dmem_busy) r_busy_mask <= 1'b0;
         case (r_state)
            PIPE_ST_RST_SEQ: begin
               r_seq_cnt <= r_seq_cnt + 2'd1;
               if (r_seq_cnt == 2'd2) r_state <= PIPE_ST_RUN;
            end
            PIPE_ST_RUN: begin
               if (w_busy_run) begin
                  r_state    <= PIPE_ST_MEM_WAIT;
                  r_wait_cnt <= 6'd1;
               end
            end
            PIPE_ST_MEM_WAIT: begin
               if (!bus.dmem_busy) begin
                  r_state <= PIPE_ST_RUN;
               end else if (w_timeout) begin
                  r_state     <= PIPE_ST_RUN;
                  r_err       <= 1'b1;
                  r_busy_mask <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 6'd1;
               end
            end
            default: r_state <= PIPE_ST_RST_SEQ;
         endcase
         if (w_freeze && !(&r_cnt_mem_wait)) r_cnt_mem_wait <= r_cnt_mem_wait + CNT_W'(1);
         if (w_flush && !(&r_cnt_flush)) r_cnt_flush <= r_cnt_flush + CNT_W'(1);
         if (w_lu_stall && !(&r_cnt_load_use)) r_cnt_load_use <= r_cnt_load_use + CNT_W'(1);
      end
   end

   assign bus.pc_we            = w_ctrl.pc_we;
   assign bus.stall_if         = w_ctrl.stall_if;
   assign bus.stall_id         = w_ctrl.stall_id;
   assign bus.stall_ex         = w_ctrl.stall_ex;
   assign bus.stall_mem        = w_ctrl.stall_mem;
   assign bus.clear_id         = w_ctrl.clear_id;
   assign bus.clear_ex         = w_ctrl.clear_ex;
   assign bus.clear_mem        = w_ctrl.clear_mem;
   assign bus.running          = !rst && (r_state != PIPE_ST_RST_SEQ);
   assign bus.err_dmem_timeout = r_err;
   assign bus.cnt_load_use     = r_cnt_load_use;
   assign bus.cnt_flush        = r_cnt_flush;
   assign bus.cnt_mem_wait     = r_cnt_mem_wait;

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Bench for the pipe sequencer: two instances (long timeout / wide counters, short timeout / 2-bit
// counters) share directed stimulus and are checked every cycle against a cycle-count model.
module tb_ama_riscv_pipe_ctrl;
   localparam int CW_A = 32, MAX_A = 15;
   localparam int CW_B = 2,  MAX_B = 3;

   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [31:0] LW_X5        = {12'd0, 5'd1, 3'b010, 5'd5, 7'b000_0011};
   localparam logic [31:0] LW_X0        = {12'd0, 5'd1, 3'b010, 5'd0, 7'b000_0011};
   localparam logic [31:0] ADD_X6_X5_X2 = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b011_0011};
   localparam logic [31:0] ADD_X6_X0_X0 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b011_0011};
   localparam logic [31:0] LUI_X5       = {20'h00028, 5'd5, 7'b011_0111};
   localparam logic [31:0] ADDI_X7_X2_5 = {12'd5, 5'd2, 3'b000, 5'd7, 7'b001_0011};
   localparam logic [31:0] SW_X5_X2     = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b010_0011};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_id = NOP;
   logic [31:0] inst_ex = NOP;
   logic        flow_change = 1'b0;
   logic        dmem_busy = 1'b0;

   int n_vec = 0;
   int n_mis = 0;

   ama_riscv_pipe_ctrl_if #(.CNT_W(CW_A)) bus_a ();
   ama_riscv_pipe_ctrl_if #(.CNT_W(CW_B)) bus_b ();

   assign bus_a.inst_id = inst_id;  assign bus_b.inst_id = inst_id;
   assign bus_a.inst_ex = inst_ex;  assign bus_b.inst_ex = inst_ex;
   assign bus_a.flow_change = flow_change;  assign bus_b.flow_change = flow_change;
   assign bus_a.dmem_busy = dmem_busy;      assign bus_b.dmem_busy = dmem_busy;

   ama_riscv_pipe_ctrl #(.CNT_W(CW_A), .DMEM_WAIT_MAX(MAX_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   ama_riscv_pipe_ctrl #(.CNT_W(CW_B), .DMEM_WAIT_MAX(MAX_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;

   // Model: cycles since reset release, length of the current freeze, and a re-arm flag.
   typedef struct {
      int     since_rst;
      int     freeze_len;
      bit     need_fresh;
      bit     err;
      longint lu, fl, mw;
   } mdl_t;

   typedef struct {
      bit [9:0] ctl;
      longint   lu, fl, mw;
   } exp_t;

   mdl_t ma, mb, na, nb;
   exp_t ea, eb;
   bit   mdl_valid = 1'b0;

   function automatic bit ref_load_use(input logic [31:0] id, input logic [31:0] ex);
      bit [6:0] op;
      bit       u1, u2;
      op = id[6:0];
      u1 = op inside {7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67};
      u2 = op inside {7'h33, 7'h23, 7'h63};
      return (ex[6:0] == 7'h03) && (ex[11:7] != 5'd0) &&
             ((u1 && id[19:15] == ex[11:7]) || (u2 && id[24:20] == ex[11:7]));
   endfunction

   function automatic longint sat_inc(input longint v, input longint cmax);
      return (v < cmax) ? v + 1 : cmax;
   endfunction

   function automatic void step_model(input mdl_t m, input int max, input longint cmax,
                                      input bit r, input bit busy, input bit fc, input bit lu,
                                      output exp_t e, output mdl_t n);
      bit pc_we, sif, sid, sex, smem, cid, cex, cmem, run;
      n = m;
      {pc_we, sif, sid, sex, smem, cid, cex, cmem, run} = '0;
      e.lu = m.lu; e.fl = m.fl; e.mw = m.mw;
      if (r) begin
         {cid, cex, cmem} = 3'b111;
         n = '{default: 0};
      end else if (m.since_rst < 3) begin
         pc_we = 1; cmem = 1;
         cex = (m.since_rst < 2);
         cid = (m.since_rst == 0);
         n.since_rst = m.since_rst + 1;
      end else begin
         run = 1;
         if (busy && !m.need_fresh && m.freeze_len < max) begin
            {sif, sid, sex, smem} = 4'b1111;
            n.freeze_len = m.freeze_len + 1;
            n.mw = sat_inc(m.mw, cmax);
         end else begin
            if (busy && !m.need_fresh) begin
               n.err = 1;
               n.need_fresh = 1;
            end
            n.freeze_len = 0;
            if (fc) begin
               {pc_we, cid, cex} = 3'b111;
               n.fl = sat_inc(m.fl, cmax);
            end else if (lu) begin
               {sif, sid, cex} = 3'b111;
               n.lu = sat_inc(m.lu, cmax);
            end else begin
               pc_we = 1;
            end
         end
      end
      if (!r && !busy) n.need_fresh = 0;
      e.ctl = {pc_we, sif, sid, sex, smem, cid, cex, cmem, run, m.err};
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mdl_valid) begin
         step_model(ma, MAX_A, (longint'(1) << CW_A) - 1, rst, dmem_busy, flow_change,
                    ref_load_use(inst_id, inst_ex), ea, na);
         step_model(mb, MAX_B, (longint'(1) << CW_B) - 1, rst, dmem_busy, flow_change,
                    ref_load_use(inst_id, inst_ex), eb, nb);
         chk("a.ctl", longint'({bus_a.pc_we, bus_a.stall_if, bus_a.stall_id, bus_a.stall_ex,
                                bus_a.stall_mem, bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem,
                                bus_a.running, bus_a.err_dmem_timeout}), longint'(ea.ctl));
         chk("a.cnt_load_use", longint'(bus_a.cnt_load_use), ea.lu);
         chk("a.cnt_flush", longint'(bus_a.cnt_flush), ea.fl);
         chk("a.cnt_mem_wait", longint'(bus_a.cnt_mem_wait), ea.mw);
         chk("b.ctl", longint'({bus_b.pc_we, bus_b.stall_if, bus_b.stall_id, bus_b.stall_ex,
                                bus_b.stall_mem, bus_b.clear_id, bus_b.clear_ex, bus_b.clear_mem,
                                bus_b.running, bus_b.err_dmem_timeout}), longint'(eb.ctl));
         chk("b.cnt_load_use", longint'(bus_b.cnt_load_use), eb.lu);
         chk("b.cnt_flush", longint'(bus_b.cnt_flush), eb.fl);
         chk("b.cnt_mem_wait", longint'(bus_b.cnt_mem_wait), eb.mw);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         ma = '{default: 0};
         mb = '{default: 0};
         mdl_valid = 1'b1;
      end else if (mdl_valid) begin
         ma = na;
         mb = nb;
      end
   end

   task automatic cyc(input bit r, input bit b, input bit f, input logic [31:0] id, input logic [31:0] ex);
      @(posedge clk); #1;
      rst = r; dmem_busy = b; flow_change = f; inst_id = id; inst_ex = ex;
      @(negedge clk);
   endtask

   initial begin
      cyc(1, 0, 0, NOP, NOP);
      cyc(1, 0, 0, NOP, NOP);
      chk("rst.ctl", longint'({bus_a.pc_we, bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem, bus_a.running}), 5'b01110);
      chk("rst.cnt", longint'(bus_a.cnt_mem_wait), 0);
      cyc(0, 0, 0, NOP, NOP);
      chk("seq0", longint'({bus_a.pc_we, bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem}), 4'b1111);
      cyc(0, 0, 0, ADD_X6_X5_X2, LW_X5);
      chk("seq1", longint'({bus_a.pc_we, bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem, bus_a.stall_if}), 5'b10110);
      cyc(0, 1, 1, NOP, NOP);
      chk("seq2", longint'({bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem, bus_a.running}), 4'b0010);
      cyc(0, 0, 0, NOP, NOP);
      chk("run", longint'({bus_a.pc_we, bus_a.clear_id, bus_a.clear_ex, bus_a.clear_mem, bus_a.running}), 5'b10001);

      cyc(0, 0, 0, ADD_X6_X5_X2, LW_X5);
      chk("lu.ctl", longint'({bus_a.pc_we, bus_a.stall_if, bus_a.stall_id, bus_a.clear_ex, bus_a.stall_ex}), 5'b01110);
      cyc(0, 0, 0, ADD_X6_X5_X2, NOP);
      chk("lu.release", longint'({bus_a.pc_we, bus_a.stall_if}), 2'b10);
      chk("lu.cnt", longint'(bus_a.cnt_load_use), 1);
      cyc(0, 0, 0, LUI_X5, LW_X5);
      chk("lui.nostall", longint'(bus_a.stall_if), 0);
      cyc(0, 0, 0, ADDI_X7_X2_5, LW_X5);
      chk("addi.nostall", longint'(bus_a.stall_if), 0);
      cyc(0, 0, 0, SW_X5_X2, LW_X5);
      chk("sw.stall", longint'(bus_a.stall_id), 1);
      cyc(0, 0, 0, ADD_X6_X0_X0, LW_X0);
      chk("x0.nostall", longint'(bus_a.stall_if), 0);

      cyc(0, 0, 1, ADD_X6_X5_X2, LW_X5);
      chk("flush.ctl", longint'({bus_a.pc_we, bus_a.clear_id, bus_a.clear_ex, bus_a.stall_if, bus_a.stall_id}), 5'b11100);
      cyc(0, 0, 0, NOP, NOP);
      chk("flush.cnt", longint'(bus_a.cnt_flush), 1);
      chk("flush.lu_cnt", longint'(bus_a.cnt_load_use), 2);

      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, NOP, NOP);
         chk("freeze.ctl", longint'({bus_a.pc_we, bus_a.stall_if, bus_a.stall_id, bus_a.stall_ex, bus_a.stall_mem}), 5'b01111);
      end
      cyc(0, 0, 0, ADD_X6_X5_X2, LW_X5);
      chk("resume.lu", longint'({bus_a.stall_if, bus_a.stall_ex, bus_a.stall_mem, bus_a.running}), 4'b1001);
      chk("freeze.cnt", longint'(bus_a.cnt_mem_wait), 4);
      chk("b.err", longint'(bus_b.err_dmem_timeout), 1);
      chk("b.mw_cnt", longint'(bus_b.cnt_mem_wait), 3);
      cyc(0, 0, 0, NOP, NOP);
      chk("lu.cnt3", longint'(bus_a.cnt_load_use), 3);

      cyc(0, 0, 0, ADD_X6_X5_X2, LW_X5);
      cyc(0, 0, 0, ADD_X6_X5_X2, LW_X5);
      cyc(0, 0, 0, NOP, NOP);
      chk("a.lu5", longint'(bus_a.cnt_load_use), 5);
      chk("b.lu_sat", longint'(bus_b.cnt_load_use), 3);

      for (int i = 0; i < 6; i++) cyc(0, 1, 0, NOP, NOP);
      chk("b.masked", longint'({bus_b.pc_we, bus_b.stall_if, bus_b.err_dmem_timeout}), 3'b101);
      chk("a.still_frozen", longint'(bus_a.stall_if), 1);
      cyc(0, 0, 0, NOP, NOP);
      cyc(0, 1, 0, NOP, NOP);
      chk("b.fresh_freeze", longint'(bus_b.stall_mem), 1);

      cyc(1, 1, 0, NOP, NOP);
      chk("abort.ctl", longint'({bus_a.pc_we, bus_a.stall_mem, bus_a.clear_id, bus_a.running}), 4'b0010);
      cyc(1, 0, 0, NOP, NOP);
      chk("b.err_clr", longint'(bus_b.err_dmem_timeout), 0);
      chk("a.mw_clr", longint'(bus_a.cnt_mem_wait), 0);
      cyc(0, 0, 0, NOP, NOP);
      chk("reseq0", longint'({bus_b.pc_we, bus_b.clear_id, bus_b.clear_ex, bus_b.clear_mem}), 4'b1111);
      cyc(0, 0, 0, NOP, NOP);
      cyc(0, 0, 0, NOP, NOP);
      cyc(0, 0, 0, NOP, NOP);
      chk("rerun", longint'({bus_a.running, bus_b.running}), 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/ama_riscv_pipe_ctrl.md
Name: ama_riscv_pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). It owns every stall, clear and PC write-enable decision. It runs the post-reset clearing sequence, detects load-use hazards between EX and ID, flushes on a resolved flow change, and freezes the pipe while data memory is busy. It sits beside the instruction decoder: the decoder supplies flow_change, and this block drives the pipeline-register controls and pc_we.

Parameters:
CNT_W, 32, width of the saturating performance counters
DMEM_WAIT_MAX, 15, maximum consecutive dmem_busy cycles before timeout (1..2^6-1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_id  in  32  instruction in ID
inst_ex  in  32  instruction in EX
flow_change  in  1  taken branch or jump resolved in EX (from decoder)
dmem_busy  in  1  data memory not ready; MEM must hold
pc_we  out  1  PC write enable
stall_if  out  1  hold IF/ID register
stall_id  out  1  hold ID/EX register
stall_ex  out  1  hold EX/MEM register
stall_mem  out  1  hold MEM/WB register
clear_id  out  1  bubble into ID/EX
clear_ex  out  1  bubble into EX/MEM
clear_mem  out  1  bubble into MEM/WB
running  out  1  state == RUN or MEM_WAIT
err_dmem_timeout  out  1  sticky; cleared only by rst
cnt_load_use  out  CNT_W  load-use stall cycles, saturating
cnt_flush  out  CNT_W  flow-change flushes, saturating
cnt_mem_wait  out  CNT_W  dmem_busy freeze cycles, saturating

Behaviour:
- States: RST_SEQ, RUN, MEM_WAIT. 2-bit seq_cnt, 6-bit wait_cnt.
- While rst=1: state<=RST_SEQ; seq_cnt<=0; wait_cnt<=0; counters<=0; err<=0. Outputs: clear_id/ex/mem=1, all stalls=0, pc_we=0, running=0.
- RST_SEQ, after rst falls: pc_we=1. Hazards and flow_change are ignored. seq_cnt=0 gives clear_id,ex,mem=1. seq_cnt=1 gives clear_ex,mem=1. seq_cnt=2 gives clear_mem=1, then next state is RUN. Exactly 3 cycles.
- rs usage in ID, by opcode. R-type, STORE, BRANCH use rs1 and rs2. I-type, LOAD, JALR use rs1. LUI, AUIPC, JAL and unknown opcodes use none.
- load_use = opc(inst_ex)==LOAD && rd_ex!=0 && a used rs in ID equals rd_ex.
- RUN priority, highest first:
  1. dmem_busy: all stalls=1, pc_we=0, no clears; next state MEM_WAIT, wait_cnt<=1, cnt_mem_wait++.
  2. flow_change: clear_id=1, clear_ex=1, pc_we=1, no stalls; cnt_flush++. A load-use in the same cycle is discarded, because the ID instruction is wrong-path.
  3. load_use: stall_if=1, stall_id=1, pc_we=0, clear_ex=1 (bubble into MEM); cnt_load_use++. Combinational and single-cycle; the next cycle re-evaluates.
  4. Otherwise: pc_we=1 and all other controls 0.
- MEM_WAIT: all stalls=1, pc_we=0, cnt_mem_wait++ per cycle.
  - dmem_busy=0: return to RUN and re-evaluate RUN rules in that cycle. A flow_change or load_use held in EX is handled then.
  - wait_cnt==DMEM_WAIT_MAX with dmem_busy=1: set err_dmem_timeout, go to RUN, treat dmem_busy as 0 for that cycle, and require a fresh assertion before freezing again.
- Counters saturate at all-ones and do not wrap.
- rst during any state aborts immediately to RST_SEQ.

Decomposition:
- Opcode constants (OPC7_*) and field slices belong in the shared defines file, which already holds the decoder opcodes.
- Add a PIPE_ST_* state encoding to the shared defines.
- One natural sub-module: ama_riscv_hazard_det, a combinational rs-usage and load-use compare on inst_id/inst_ex.
- Counters stay inline.

Test Plan:
- Reset: rst held 2 cycles then released → clears {id,ex,mem} = 111, 011, 001 on the next 3 cycles; running=1 on the 4th; pc_we=1 from the first post-reset cycle.
- Load-use: EX=lw x5,0(x1), ID=add x6,x5,x2 → one cycle of stall_if=stall_id=clear_ex=1, pc_we=0; cnt_load_use=1. Same with ID=lui x5 → no stall.
- rd=x0: EX=lw x0, ID=add x6,x0,x0 → no stall.
- Flush priority: flow_change=1 with a load-use present → clear_id=clear_ex=1, pc_we=1, no stall; cnt_flush=1, cnt_load_use=0.
- Mem freeze: dmem_busy for 4 cycles → 4 cycles of all stalls=1, pc_we=0; cnt_mem_wait=4; RUN resumes on the 5th cycle.
- Timeout: DMEM_WAIT_MAX=3, dmem_busy stuck at 1 → err_dmem_timeout=1 after 3 cycles, stays set; rst clears it and restarts RST_SEQ.
